core_mem_arbiter: RTL
=====================

# core_mem_arbiter

Two-master to one-slave memory arbiter sitting between a processor core and the Controller's single main-memory port. It accepts independent instruction-fetch and data (load/store) requests from the core and serialises them onto the Controller port with round-robin arbitration, registered request outputs and a response timeout. It returns a one-cycle response pulse with read data or an error flag to the requesting side.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- TIMEOUT_CYCLES, 1024, ISSUE cycles without `mem_response` before error; 0 disables timeout (16-bit counter)

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (low = reset)
- instr_req  in  1  fetch request, level, held until `instr_rsp`
- instr_addr  in  ADDR_WIDTH  fetch address, stable while `instr_req`
- instr_rsp  out  1  one-cycle response pulse
- instr_rdata  out  DATA_WIDTH  fetch data, valid with `instr_rsp`
- instr_err  out  1  timeout flag, valid with `instr_rsp`
- data_req  in  1  load/store request, level, held until `data_rsp`
- data_we  in  1  1 = store, 0 = load; stable while `data_req`
- data_addr  in  ADDR_WIDTH  load/store address
- data_wdata  in  DATA_WIDTH  store data
- data_rsp  out  1  one-cycle response pulse
- data_rdata  out  DATA_WIDTH  load data, valid with `data_rsp` (0 for stores)
- data_err  out  1  timeout flag, valid with `data_rsp`
- mem_read  out  1  read strobe to Controller, held until response
- mem_write  out  1  write strobe to Controller, held until response
- mem_address  out  ADDR_WIDTH  address to Controller
- mem_write_data  out  DATA_WIDTH  write data to Controller
- mem_response  in  1  Controller completion pulse
- mem_read_data  in  DATA_WIDTH  Controller read data, valid with `mem_response`

## Operation
- States: IDLE, ISSUE, RESP. Reset state IDLE.
- IDLE: if any request, pick winner, register address/wdata/we and `owner` bit, go ISSUE. No request: stay.
- Arbitration: only one pending -> it wins. Both pending -> the one NOT granted last wins. `last_grant` resets to data, so instruction wins the first tie.
- ISSUE: `mem_read` = owner is instr, or data with `data_we`=0; `mem_write` = data store. Address/data held constant. On `mem_response`=1: capture `mem_read_data` (reads only, else 0), err=0, go RESP. On timeout: rdata=0, err=1, go RESP; strobes drop.
- Timeout counter clears on entry to ISSUE, increments each ISSUE cycle; timeout fires when counter = TIMEOUT_CYCLES-1 with no response. Response in the same cycle as timeout wins (err=0).
- RESP: assert owner's `*_rsp` for exactly one cycle with registered rdata/err; update `last_grant`=owner; go IDLE. Non-owner's rsp stays 0.
- Requester drops `*_req` at the edge ending its RESP cycle; a req still high in IDLE is treated as a new request.
- `mem_response` outside ISSUE is ignored.
- Reset asserted anytime (incl. mid-ISSUE): state IDLE, all outputs 0 immediately, counter 0, `last_grant`=data; in-flight transaction discarded, no rsp issued.

## Timing
- All outputs registered; reset values all 0.
- Request sampled high at edge N -> `mem_read`/`mem_write` high from cycle N+1.
- `mem_response` sampled at edge M -> strobes low and `*_rsp` high in cycle M+1, low at M+2.
- Minimum request-to-response: 2 cycles (response in first ISSUE cycle). Back-to-back: next issue starts 2 cycles after rsp pulse (IDLE cycle then ISSUE).
- Timeout with TIMEOUT_CYCLES=T: strobes high exactly T cycles, then err rsp.
- Throughput: one outstanding transaction; no pipelining.

## Test plan
- Single fetch: instr_req, addr 0x100, Controller responds 3 cycles later with 0xDEADBEEF -> `mem_read` high 3 cycles, `mem_address`=0x100, `instr_rsp` one cycle with rdata 0xDEADBEEF, err 0.
- Store: data_req, we=1, addr 0x2000, wdata 0x12345678, response next cycle -> `mem_write`=1 with those values, `data_rsp` pulse, rdata 0.
- Simultaneous requests held continuously, three rounds -> grants instr, data, instr; each rsp pulse only to owner.
- Timeout: TIMEOUT_CYCLES=8, no response -> strobe high 8 cycles, `instr_rsp`=1 with err 1, rdata 0; late `mem_response` afterwards ignored.
- Reset low mid-ISSUE -> all outputs 0 same cycle; after release with no req, no rsp ever issued; next tie grants instr.
- Response coinciding with final timeout cycle (TIMEOUT_CYCLES=4, response in 4th cycle) -> err 0, data returned.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// Round-robin arbiter joining instruction-fetch and load/store requests
// onto one main-memory port, with a response timeout.
module core_mem_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    output logic                  instr_rsp,
    output logic [DATA_WIDTH-1:0] instr_rdata,
    output logic                  instr_err,
    input  logic                  data_req,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic                  data_rsp,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_err,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_response,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t state_q, state_d;

    // owner/last_grant: 1 = data side, 0 = instruction side
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;

    logic                  mem_read_d, mem_write_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic                  instr_rsp_d, data_rsp_d;
    logic [DATA_WIDTH-1:0] instr_rdata_d, data_rdata_d;
    logic                  instr_err_d, data_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic win_data;
    logic rd_txn;
    logic timeout;

    assign win_data = data_req & (~instr_req | ~last_q);
    assign rd_txn   = ~owner_q | ~we_q;
    assign timeout  = TO_EN && (cnt_q == TO_LAST);

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        mem_read_d    = mem_read;
        mem_write_d   = mem_write;
        addr_d        = mem_address;
        wdata_d       = mem_write_data;
        instr_rsp_d   = 1'b0;
        data_rsp_d    = 1'b0;
        instr_rdata_d = instr_rdata;
        instr_err_d   = instr_err;
        data_rdata_d  = data_rdata;
        data_err_d    = data_err;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (instr_req || data_req) begin
                    state_d = ISSUE;
                    owner_d = win_data;
                    cnt_d   = '0;
                    if (win_data) begin
                        we_d        = data_we;
                        addr_d      = data_addr;
                        wdata_d     = data_wdata;
                        mem_read_d  = ~data_we;
                        mem_write_d = data_we;
                    end else begin
                        we_d        = 1'b0;
                        addr_d      = instr_addr;
                        wdata_d     = '0;
                        mem_read_d  = 1'b1;
                        mem_write_d = 1'b0;
                    end
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 16'd1;
                // a response on the last timeout cycle still counts as success
                if (mem_response || timeout) begin
                    state_d     = RESP;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    rsp_err     = ~mem_response;
                    if (mem_response && rd_txn) begin
                        rsp_rdata = mem_read_data;
                    end
                    if (owner_q) begin
                        data_rsp_d   = 1'b1;
                        data_rdata_d = rsp_rdata;
                        data_err_d   = rsp_err;
                    end else begin
                        instr_rsp_d   = 1'b1;
                        instr_rdata_d = rsp_rdata;
                        instr_err_d   = rsp_err;
                    end
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            we_q           <= 1'b0;
            last_q         <= 1'b1;
            cnt_q          <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            instr_rsp      <= 1'b0;
            instr_rdata    <= '0;
            instr_err      <= 1'b0;
            data_rsp       <= 1'b0;
            data_rdata     <= '0;
            data_err       <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            we_q           <= we_d;
            last_q         <= last_d;
            cnt_q          <= cnt_d;
            mem_read       <= mem_read_d;
            mem_write      <= mem_write_d;
            mem_address    <= addr_d;
            mem_write_data <= wdata_d;
            instr_rsp      <= instr_rsp_d;
            instr_rdata    <= instr_rdata_d;
            instr_err      <= instr_err_d;
            data_rsp       <= data_rsp_d;
            data_rdata     <= data_rdata_d;
            data_err       <= data_err_d;
        end
    end

endmodule
